async_fifo_wptr_full: RTL and testbench

Write-domain pointer and full-flag stage of the async FIFO.
- Maintains the binary write address and a registered Gray-coded write pointer. The Gray pointer feeds the two-flop synchronizer into the read domain.
- Consumes the read pointer after it has been synchronized into the write domain. From it, derives a registered full flag, a memory write enable and a sticky overflow error.

---
 rtl/async_fifo_pkg.sv | 29 ++
 rtl/async_fifo_wptr_full.sv | 96 +++++++++
 tb/tb_async_fifo_wptr_full.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO: default sizing, pointer type,
// and Gray/binary conversion helpers.
// The helpers work on a wide word so any pointer width up to 32 bits can use them.
package async_fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int AF_THRESH_DEF  = 14;
  localparam int PTR_MAX_W      = 32;

  // Pointer at the default address width (ADDR_WIDTH+1 bits).
  typedef logic [ADDR_WIDTH_DEF:0] ptr_t;
  // Container for width-generic conversions; callers zero-extend in and truncate out.
  typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

  function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
    ptr_wide_t b;
    b = g;
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer / full-flag stage of the async FIFO.
// Ports: clk, rst_n (async active-low), winc (write request), wq2_rptr (Gray read ptr
//   synced into clk domain) -> wr_en, waddr, wptr (registered Gray), wfull, overflow_err,
//   and almost_full when built with FIFO_ALMOST_FULL_EN.
// wfull asserts on the filling edge; it releases one edge after a new wq2_rptr arrives.
module async_fifo_wptr_full
  import async_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AF_THRESH  = AF_THRESH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  overflow_err
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  // Reject illegal configurations at elaboration time.
  if (ADDR_WIDTH < 2 || AF_THRESH < 1 || AF_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_params
    $error("async_fifo_wptr_full: illegal ADDR_WIDTH/AF_THRESH");
  end

  logic [ADDR_WIDTH:0] wbin_q, wbin_d;
  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] full_cmp;
  logic                wfull_q, wfull_d;
  logic                overflow_q, overflow_d;

  assign wr_en        = winc & ~wfull_q;
  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign overflow_err = overflow_q;

  always_comb begin
    wbin_d = wbin_q + {{ADDR_WIDTH{1'b0}}, wr_en};
    wptr_d = PW'(bin2gray(ptr_wide_t'(wbin_d)));
    // In Gray code, "writer exactly one lap ahead" means the two MSBs differ
    // from the read pointer while all lower bits match.
    full_cmp   = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
    // Comparing against the next pointer lets the filling write raise wfull on its own edge.
    wfull_d    = (wptr_d == full_cmp);
    overflow_d = overflow_q | (winc & wfull_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q     <= '0;
      wptr_q     <= '0;
      wfull_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wptr_q     <= wptr_d;
      wfull_q    <= wfull_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] AF_LIMIT = PW'(AF_THRESH);

  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] wcount;
  logic                almost_full_q, almost_full_d;

  always_comb begin
    rbin          = PW'(gray2bin(ptr_wide_t'(wq2_rptr)));
    // Modulo subtraction on the extra-bit pointers yields occupancy 0..depth.
    wcount        = wbin_d - rbin;
    almost_full_d = (wcount >= AF_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
module tb_async_fifo_wptr_full;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;
  localparam int AF    = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          winc = 1'b0;
  logic [AW:0]   wq2_rptr = '0;
  logic          wr_en;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          overflow_err;
  logic          almost_full;

  async_fifo_wptr_full dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wr_en        (wr_en),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .overflow_err (overflow_err)
`ifdef FIFO_ALMOST_FULL_EN
    ,
    .almost_full  (almost_full)
`endif
  );

`ifndef FIFO_ALMOST_FULL_EN
  assign almost_full = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic          wr_en;
    logic [AW:0]   wptr;
    logic [AW-1:0] waddr;
    logic          wfull;
    logic          ovf;
    logic          af;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: count of accepted writes, occupancy against the read side.
  int m_wbin = 0;
  bit m_ovf  = 0;
  bit m_full = 0;
  bit m_af   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [AW:0] b2g(input int b);
    logic [AW:0] x;
    x = b[AW:0];
    return x ^ (x >> 1);
  endfunction

  // Gray-to-binary by search: the binary value whose Gray image matches.
  function automatic int g2b(input logic [AW:0] g);
    for (int b = 0; b < PMOD; b++) begin
      if (b2g(b) == g) return b;
    end
    return 0;
  endfunction

  function automatic void model_reset();
    m_wbin = 0;
    m_ovf  = 0;
    m_full = 0;
    m_af   = 0;
  endfunction

  // Drive one cycle of stimulus and queue what the DUT should show.
  task automatic cycle(input logic w, input logic [AW:0] rg);
    exp_t e;
    int   occ;
    @(negedge clk);
    winc     = w;
    wq2_rptr = rg;
    e.wr_en  = w && !m_full;
    if (w && m_full) m_ovf = 1;
    m_wbin = (m_wbin + (e.wr_en ? 1 : 0)) % PMOD;
    occ    = (m_wbin - g2b(rg) + PMOD) % PMOD;
    m_full = (occ == DEPTH);
    m_af   = (occ >= AF);
    e.wptr  = b2g(m_wbin);
    e.waddr = 4'(m_wbin % DEPTH);
    e.wfull = m_full;
    e.ovf   = m_ovf;
    e.af    = m_af;
    exp_q.push_back(e);
  endtask

  // Wait until the monitor has finished the last queued cycle (posedge + 3).
  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    winc     = 1'b0;
    wq2_rptr = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation per driven cycle, checks wr_en before the edge
  // and the registered state after it.
  initial begin : monitor
    exp_t        e;
    logic [AW:0] prev;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        prev = wptr;
        chk("wr_en", 32'(wr_en), 32'(e.wr_en));
        @(posedge clk);
        #1;
        chk("wptr", 32'(wptr), 32'(e.wptr));
        chk("waddr", 32'(waddr), 32'(e.waddr));
        chk("wfull", 32'(wfull), 32'(e.wfull));
        chk("overflow_err", 32'(overflow_err), 32'(e.ovf));
`ifdef FIFO_ALMOST_FULL_EN
        chk("almost_full", 32'(almost_full), 32'(e.af));
`endif
        if (e.wr_en) chk("wptr_onebit", 32'($countones(prev ^ wptr)), 32'd1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [AW:0] hist[$];
    logic [AW:0] rq[$];
    logic [AW:0] rg;
    int          rb;
    logic        w;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wptr", 32'(wptr), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wfull", 32'(wfull), 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 16 entries with the reader idle
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, '0);
    settle();
    chk("fill_wptr", 32'(wptr), 32'b11000);
    chk("fill_wfull", 32'(wfull), 32'd1);
    chk("fill_waddr", 32'(waddr), 32'd0);

    // Overflow: keep writing while full, then drop winc
    repeat (3) cycle(1'b1, '0);
    cycle(1'b0, '0);
    settle();
    chk("ovf_sticky", 32'(overflow_err), 32'd1);
    chk("ovf_wptr_hold", 32'(wptr), 32'b11000);

    // Release: reader frees one slot
    cycle(1'b0, 5'b00001);
    settle();
    chk("release_wfull", 32'(wfull), 32'd0);
    cycle(1'b1, 5'b00001);
    settle();
    chk("release_wptr", 32'(wptr), 32'b11001);

    // Async reset in the middle of a write burst, between clock edges
    for (int i = 0; i < 3; i++) cycle(1'b1, b2g(17));
    settle();
    rst_n = 1'b0;
    #1;
    chk("arst_wptr", 32'(wptr), 32'd0);
    chk("arst_waddr", 32'(waddr), 32'd0);
    chk("arst_wfull", 32'(wfull), 32'd0);
    chk("arst_ovf", 32'(overflow_err), 32'd0);
    model_reset();
    @(negedge clk);
    winc     = 1'b0;
    wq2_rptr = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap: 40 writes with the read pointer trailing three cycles behind
    for (int i = 0; i < 40; i++) begin
      rg = (hist.size() >= 3) ? hist[hist.size()-3] : '0;
      cycle(1'b1, rg);
      hist.push_back(b2g(m_wbin));
    end
    settle();
    chk("wrap_wptr", 32'(wptr), 32'(b2g(40 % PMOD)));
    chk("wrap_wfull", 32'(wfull), 32'd0);

    // Randomized traffic: reader advances at varying rates, seen through a 2-flop delay
    do_reset();
    rb = 0;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 3) != 0);
      if (rb != m_wbin && $urandom_range(0, 99) < ((i < 200) ? 20 : 70))
        rb = (rb + 1) % PMOD;
      rq.push_back(b2g(rb));
      rg = (rq.size() >= 3) ? rq[rq.size()-3] : '0;
      cycle(w, rg);
    end
    settle();

`ifdef FIFO_ALMOST_FULL_EN
    // Almost-full threshold crossing and release
    do_reset();
    for (int i = 0; i < AF - 1; i++) cycle(1'b1, '0);
    settle();
    chk("af_13", 32'(almost_full), 32'd0);
    cycle(1'b1, '0);
    settle();
    chk("af_14", 32'(almost_full), 32'd1);
    cycle(1'b0, 5'b00011);
    settle();
    chk("af_clear", 32'(almost_full), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
